audio_sample_buffer: RTL

- Upstream feeder of the HDMI audio sample packet generator, in the clk_pixel domain.
- Accepts one stereo L-PCM sample per input strobe and queues it in a small FIFO.
- On each grant from the data-island scheduler, presents up to four queued samples plus the IEC 60958 frame counter in the exact form the sample-packet builder consumes.
- Tracks the 192-frame channel-status block position across packets.

---
 rtl/audio_sample_buffer.sv | 109 ++++++++++
 1 files changed

// File: rtl/audio_sample_buffer.sv
// Stereo L-PCM sample FIFO feeding the HDMI audio sample packet builder.
// Each scheduler grant drains up to MAX_SAMPLES samples and labels slot 0 with its IEC 60958 frame index.
module audio_sample_buffer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_SAMPLES = 4,
    parameter int BIT_WIDTH   = 24
) (
    input  logic                          clk_pixel,
    input  logic                          reset_n,
    input  logic                          sample_valid,
    input  logic [BIT_WIDTH-1:0]          sample_left,
    input  logic [BIT_WIDTH-1:0]          sample_right,
    input  logic                          packet_grant,
    output logic                          packet_pending,
    output logic [3:0][1:0][23:0]         audio_sample_word,
    output logic [3:0]                    audio_sample_word_present,
    output logic [7:0]                    frame_counter,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [BIT_WIDTH-1:0]  r_mem_l [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0]  r_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_pending;
    logic                  r_overflow;
    logic [3:0][1:0][23:0] r_word;
    logic [3:0]            r_present;
    logic [7:0]            r_fc;
    logic [7:0]            r_next_fc;

    logic [2:0]            w_avail;
    logic [2:0]            w_k;
    logic                  w_push_ok;
    logic [CW-1:0]         w_count_next;
    logic [3:0][1:0][23:0] w_word;
    logic [3:0]            w_present;
    logic [8:0]            w_fc_sum;
    logic [7:0]            w_fc_wrapped;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_avail      = (r_count > CW'(MAX_SAMPLES)) ? 3'(MAX_SAMPLES) : 3'(r_count);
        w_k          = packet_grant ? w_avail : 3'd0;
        // A grant frees its slots in the same cycle, so a push into a full FIFO can still land.
        w_push_ok    = sample_valid && ((r_count - CW'(w_k)) < CW'(FIFO_DEPTH));
        w_count_next = r_count - CW'(w_k) + CW'(w_push_ok);
        w_fc_sum     = {1'b0, r_next_fc} + 9'(w_k);
        w_fc_wrapped = (w_fc_sum >= 9'd192) ? 8'(w_fc_sum - 9'd192) : w_fc_sum[7:0];
        for (int i = 0; i < 4; i++) begin
            w_present[i] = (3'(i) < w_k);
            w_word[i][0] = w_present[i] ? 24'(r_mem_l[r_rd_ptr + AW'(i)]) : 24'd0;
            w_word[i][1] = w_present[i] ? 24'(r_mem_r[r_rd_ptr + AW'(i)]) : 24'd0;
        end
    end

    // NOTE: sample storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_pixel) begin
        if (w_push_ok) begin
            r_mem_l[r_wr_ptr] <= sample_left;
            r_mem_r[r_wr_ptr] <= sample_right;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_word     <= '0;
            r_present  <= 4'b0000;
            r_fc       <= 8'd0;
            r_next_fc  <= 8'd0;
        end else begin
            r_count   <= w_count_next;
            r_pending <= (w_count_next != '0);
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (sample_valid && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (packet_grant) begin
                // r_next_fc already includes the previous packet's sample count.
                r_rd_ptr  <= r_rd_ptr + AW'(w_k);
                r_word    <= w_word;
                r_present <= w_present;
                r_fc      <= r_next_fc;
                r_next_fc <= w_fc_wrapped;
            end
        end
    end

    assign packet_pending            = r_pending;
    assign audio_sample_word         = r_word;
    assign audio_sample_word_present = r_present;
    assign frame_counter             = r_fc;
    assign fifo_level                = r_count;
    assign overflow                  = r_overflow;

endmodule
